// File: rtl/lcd_bus_rx_if.sv
// lcd_bus_rx_if: 8-bit 8080-style LCD write bus (controller -> panel).
interface lcd_bus_rx_if;
  logic [7:0] lcd_db;
  logic       lcd_wr;
  logic       lcd_d_c;
  logic       lcd_rd;
  logic       lcd_reset;

  modport master (output lcd_db, output lcd_wr, output lcd_d_c, output lcd_rd, output lcd_reset);
  modport slave  (input  lcd_db, input  lcd_wr, input  lcd_d_c, input  lcd_rd, input  lcd_reset);
endinterface

// File: rtl/lcd_bus_rx.sv
// lcd_bus_rx: receiving end of the 8-bit 8080-style LCD write bus.
// Decodes SWRESET/DISPOFF/DISPON/CASET/PASET/RAMWR, rebuilds RGB565 pixels
// from byte pairs and emits them as 4-bit R/G/B with window-tracked x/y.
// Optional feature: define LCD_RX_DROP_CNT_EN to add the saturating drop_cnt port.
module lcd_bus_rx #(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_100,
  input  logic        resetN,
  lcd_bus_rx_if.slave bus,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_done,
  output logic        disp_on
`ifdef LCD_RX_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam logic [9:0] XMAX = 10'(WIDTH - 1);
  localparam logic [9:0] YMAX = 10'(HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, PARAM, SKIP, RAM_HI, RAM_LO} state_t;

  // {lcd_reset, lcd_wr, lcd_d_c, lcd_db} travel together so db/d_c line up with wr
  logic [10:0] w_bus_raw, w_bus_s;
  assign w_bus_raw = {bus.lcd_reset, bus.lcd_wr, bus.lcd_d_c, bus.lcd_db};

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign w_bus_s = w_bus_raw;
    end else begin : g_sync
      logic [10:0] r_sync [SYNC_STAGES];
      // Synchronizer chain; idles high so a high wr/reset line gives no false edge after reset
      always_ff @(posedge clk_100 or negedge resetN) begin
        if (!resetN) begin
          for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
        end else begin
          r_sync[0] <= w_bus_raw;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end
      assign w_bus_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  logic       w_lrst_n, w_wr_s, w_dc_s, w_wr_rise;
  logic [7:0] w_db_s;
  assign w_lrst_n  = w_bus_s[10];
  assign w_wr_s    = w_bus_s[9];
  assign w_dc_s    = w_bus_s[8];
  assign w_db_s    = w_bus_s[7:0];

  logic       r_wr_prev, r_byte_vld, r_dc;
  logic [7:0] r_byte;
  assign w_wr_rise = w_wr_s & ~r_wr_prev;

  // Byte capture on the synchronized wr rising edge
  always_ff @(posedge clk_100 or negedge resetN) begin
    if (!resetN) begin
      r_wr_prev  <= 1'b1;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
      r_dc       <= 1'b0;
    end else begin
      r_wr_prev  <= w_wr_s;
      r_byte_vld <= w_wr_rise & w_lrst_n;
      if (w_wr_rise) begin
        r_byte <= w_db_s;
        r_dc   <= w_dc_s;
      end
    end
  end

  state_t     r_state, w_state_nxt;
  logic [1:0] r_pcnt;
  logic       r_is_pa;
  logic [7:0] r_p0, r_p1, r_p2, r_hi;
  logic [9:0] r_sc, r_ec, r_sp, r_ep, r_cx, r_cy;
  logic       w_sw_rst, w_disp_ld, w_param_start, w_param_ld, w_commit;
  logic       w_ramwr, w_hi_ld, w_pix, w_abort_half, w_clr, w_win_ok;

  assign w_clr    = ~w_lrst_n | w_sw_rst;
  assign w_win_ok = (r_sc <= r_ec) && (r_sp <= r_ep);

  // Command/data decode: next state and one-cycle datapath strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_sw_rst      = 1'b0;
    w_disp_ld     = 1'b0;
    w_param_start = 1'b0;
    w_param_ld    = 1'b0;
    w_commit      = 1'b0;
    w_ramwr       = 1'b0;
    w_hi_ld       = 1'b0;
    w_pix         = 1'b0;
    w_abort_half  = 1'b0;
    if (!w_lrst_n) begin
      w_state_nxt = IDLE;
    end else if (r_byte_vld) begin
      if (!r_dc) begin
        w_abort_half = (r_state == RAM_LO);
        case (r_byte)
          8'h01:        begin w_sw_rst      = 1'b1; w_state_nxt = IDLE;   end
          8'h28, 8'h29: begin w_disp_ld     = 1'b1; w_state_nxt = IDLE;   end
          8'h2A, 8'h2B: begin w_param_start = 1'b1; w_state_nxt = PARAM;  end
          8'h2C:        begin w_ramwr       = 1'b1; w_state_nxt = RAM_HI; end
          default:      w_state_nxt = SKIP;
        endcase
      end else begin
        case (r_state)
          PARAM: begin
            w_param_ld = 1'b1;
            if (r_pcnt == 2'd3) begin
              w_commit    = 1'b1;
              w_state_nxt = IDLE;
            end
          end
          RAM_HI:  begin w_hi_ld = 1'b1; w_state_nxt = RAM_LO; end
          RAM_LO:  begin w_pix   = 1'b1; w_state_nxt = RAM_HI; end
          default: ;
        endcase
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_100 or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  logic [9:0] w_lim, w_start, w_end, w_start_c, w_end_c;
  assign w_lim     = r_is_pa ? YMAX : XMAX;
  assign w_start   = {r_p0[1:0], r_p1};
  assign w_end     = {r_p2[1:0], r_byte};
  assign w_start_c = (w_start > w_lim) ? w_lim : w_start;
  assign w_end_c   = (w_end   > w_lim) ? w_lim : w_end;

  // Window, cursor, pixel output and display-status registers
  always_ff @(posedge clk_100 or negedge resetN) begin
    if (!resetN) begin
      pix_valid <= 1'b0; frame_done <= 1'b0; disp_on <= 1'b0;
      pix_x <= '0; pix_y <= '0; red <= '0; green <= '0; blue <= '0;
      r_sc <= '0; r_ec <= XMAX; r_sp <= '0; r_ep <= YMAX; r_cx <= '0; r_cy <= '0;
      r_pcnt <= '0; r_is_pa <= 1'b0; r_p0 <= '0; r_p1 <= '0; r_p2 <= '0; r_hi <= '0;
    end else if (w_clr) begin
      pix_valid <= 1'b0; frame_done <= 1'b0; disp_on <= 1'b0;
      pix_x <= '0; pix_y <= '0; red <= '0; green <= '0; blue <= '0;
      r_sc <= '0; r_ec <= XMAX; r_sp <= '0; r_ep <= YMAX; r_cx <= '0; r_cy <= '0;
      r_pcnt <= '0; r_is_pa <= 1'b0; r_p0 <= '0; r_p1 <= '0; r_p2 <= '0; r_hi <= '0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (w_disp_ld) disp_on <= r_byte[0];
      if (w_param_start) begin
        r_pcnt  <= '0;
        r_is_pa <= r_byte[0];
      end
      if (w_param_ld) begin
        r_pcnt <= r_pcnt + 2'd1;
        case (r_pcnt)
          2'd0:    r_p0 <= r_byte;
          2'd1:    r_p1 <= r_byte;
          2'd2:    r_p2 <= r_byte;
          default: ;
        endcase
      end
      if (w_commit) begin
        if (r_is_pa) begin r_sp <= w_start_c; r_ep <= w_end_c; end
        else         begin r_sc <= w_start_c; r_ec <= w_end_c; end
      end
      if (w_ramwr) begin
        r_cx <= r_sc;
        r_cy <= r_sp;
      end
      if (w_hi_ld) r_hi <= r_byte;
      if (w_pix && w_win_ok) begin
        pix_valid <= 1'b1;
        pix_x     <= r_cx;
        pix_y     <= r_cy;
        red       <= r_hi[7:4];
        green     <= {r_hi[2:0], r_byte[7]};
        blue      <= r_byte[4:1];
        if (r_cx < r_ec) begin
          r_cx <= r_cx + 10'd1;
        end else if (r_cy < r_ep) begin
          r_cx <= r_sc;
          r_cy <= r_cy + 10'd1;
        end else begin
          r_cx       <= r_sc;
          r_cy       <= r_sp;
          frame_done <= 1'b1;
        end
      end
    end
  end

`ifdef LCD_RX_DROP_CNT_EN
  // Saturating count of pixels lost to an invalid window or a command abort
  always_ff @(posedge clk_100 or negedge resetN) begin
    if (!resetN)                   drop_cnt <= '0;
    else if (w_clr)                drop_cnt <= '0;
    else if ((w_abort_half || (w_pix && !w_win_ok)) && (drop_cnt != '1))
                                   drop_cnt <= drop_cnt + 16'd1;
  end
`endif

  logic w_unused;
  assign w_unused = ^{bus.lcd_rd, r_hi[3], r_p0[7:2], r_p2[7:2]};

endmodule

// File: tb/tb_lcd_bus_rx.sv
// tb_lcd_bus_rx: drives lcd_bus_rx through the 8080 write bus and compares
// emitted pixels, status and drop count with a byte-stream reference model.
`timescale 1ns/1ps
module tb_lcd_bus_rx;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HOLD = SYNC + 1;
  localparam int unsigned W = 320;
  localparam int unsigned H = 240;

  logic clk_100 = 1'b0;
  logic resetN  = 1'b0;
  lcd_bus_rx_if bus();
  logic       pix_valid, frame_done, disp_on;
  logic [9:0] pix_x, pix_y;
  logic [3:0] red, green, blue;
`ifdef LCD_RX_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  lcd_bus_rx #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(SYNC)) dut (
    .clk_100(clk_100), .resetN(resetN), .bus(bus),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .red(red), .green(green), .blue(blue),
    .frame_done(frame_done), .disp_on(disp_on)
`ifdef LCD_RX_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk_100 = ~clk_100;

  typedef struct packed {
    logic [9:0] x, y;
    logic [3:0] r, g, b;
    logic       fd;
  } pix_t;

  typedef struct {
    logic [7:0] hi, lo;
    logic [3:0] r, g, b;
  } vec_t;

  pix_t obs_q[$];
  pix_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: window, pixel count since RAMWR, pending high byte
  localparam int M_IDLE = 0, M_PARAM = 1, M_RAM = 2;
  int m_sc, m_ec, m_sp, m_ep, m_mode, m_n, m_disp, m_drop, m_half, m_pa, m_hi;
  int m_pq[$];

  always @(posedge clk_100) begin
    #1;
    if (pix_valid) obs_q.push_back(pix_t'({pix_x, pix_y, red, green, blue, frame_done}));
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic m_reset();
    m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1;
    m_mode = M_IDLE; m_n = 0; m_disp = 0; m_drop = 0; m_half = 0; m_pa = 0;
    m_pq.delete();
  endtask

  task automatic m_drop_inc();
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic m_byte(input logic dc, input logic [7:0] b);
    int s, e, lim, w, h, idx, rgb;
    if (!dc) begin
      if (m_mode == M_RAM && m_half != 0) m_drop_inc();
      m_half = 0;
      m_mode = M_IDLE;
      case (b)
        8'h01: m_reset();
        8'h28: m_disp = 0;
        8'h29: m_disp = 1;
        8'h2A, 8'h2B: begin m_mode = M_PARAM; m_pa = (b == 8'h2B); m_pq.delete(); end
        8'h2C: begin m_mode = M_RAM; m_n = 0; end
        default: ;
      endcase
    end else if (m_mode == M_PARAM) begin
      m_pq.push_back(int'(b));
      if (m_pq.size() == 4) begin
        lim = m_pa ? H - 1 : W - 1;
        s = (m_pq[0] * 256 + m_pq[1]) % 1024;
        e = (m_pq[2] * 256 + m_pq[3]) % 1024;
        if (s > lim) s = lim;
        if (e > lim) e = lim;
        if (m_pa) begin m_sp = s; m_ep = e; end
        else      begin m_sc = s; m_ec = e; end
        m_mode = M_IDLE;
      end
    end else if (m_mode == M_RAM) begin
      if (m_half == 0) begin
        m_hi = int'(b);
        m_half = 1;
      end else begin
        m_half = 0;
        rgb = m_hi * 256 + int'(b);
        if (m_sc <= m_ec && m_sp <= m_ep) begin
          w = m_ec - m_sc + 1;
          h = m_ep - m_sp + 1;
          idx = m_n % (w * h);
          exp_q.push_back(pix_t'({10'(m_sc + idx % w), 10'(m_sp + idx / w),
                                  4'(rgb / 4096), 4'(rgb / 128), 4'(rgb / 2),
                                  1'(idx == w * h - 1)}));
          m_n++;
        end else begin
          m_drop_inc();
        end
      end
    end
  endtask

  task automatic wr_byte(input logic dc, input logic [7:0] b);
    @(negedge clk_100);
    bus.lcd_db  = b;
    bus.lcd_d_c = dc;
    bus.lcd_rd  = 1'($urandom_range(0, 1));
    bus.lcd_wr  = 1'b0;
    repeat (HOLD) @(negedge clk_100);
    bus.lcd_wr  = 1'b1;
    repeat (HOLD - 1) @(negedge clk_100);
  endtask

  task automatic send(input logic dc, input logic [7:0] b);
    m_byte(dc, b);
    wr_byte(dc, b);
  endtask

  task automatic send4(input logic [7:0] cmd, input int s, input int e);
    send(1'b0, cmd);
    send(1'b1, 8'(s / 256)); send(1'b1, 8'(s));
    send(1'b1, 8'(e / 256)); send(1'b1, 8'(e));
  endtask

  task automatic drain();
    repeat (SYNC + 6) @(negedge clk_100);
  endtask

  task automatic chk_at(input string name, input int i, input int x, input int y, input int fd);
    if (i < obs_q.size()) begin
      chk({name, "_x"}, int'(obs_q[i].x), x);
      chk({name, "_y"}, int'(obs_q[i].y), y);
      chk({name, "_fd"}, int'(obs_q[i].fd), fd);
    end else begin
      chk({name, "_present"}, obs_q.size(), i + 1);
    end
  endtask

  task automatic check_pix(input string name);
    int n;
    drain();
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_pix[%0d] got=%h want=%h", name, i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_drop(input string name, input int want);
`ifdef LCD_RX_DROP_CNT_EN
    chk(name, int'(drop_cnt), want);
`else
    if (want < 0) $display("%s", name);
`endif
  endtask

  vec_t tbl[7];
  int lat;
  int ex[5], ey[5], ef[5];

  initial begin
    tbl[0] = '{8'hF8, 8'h00, 4'hF, 4'h0, 4'h0};
    tbl[1] = '{8'h07, 8'hE0, 4'h0, 4'hF, 4'h0};
    tbl[2] = '{8'h00, 8'h1F, 4'h0, 4'h0, 4'hF};
    tbl[3] = '{8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF};
    tbl[4] = '{8'h12, 8'h34, 4'h1, 4'h4, 4'hA};
    tbl[5] = '{8'hA5, 8'h5A, 4'hA, 4'hA, 4'hD};
    tbl[6] = '{8'h08, 8'h80, 4'h0, 4'h1, 4'h0};
    ex = '{10, 11, 10, 11, 10};
    ey = '{20, 20, 21, 21, 20};
    ef = '{0, 0, 0, 1, 0};

    bus.lcd_db = '0; bus.lcd_d_c = 1'b0; bus.lcd_wr = 1'b1;
    bus.lcd_rd = 1'b1; bus.lcd_reset = 1'b1;
    m_reset();
    repeat (3) @(negedge clk_100);
    resetN = 1'b1;
    repeat (4) @(negedge clk_100);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_xy", int'({pix_x, pix_y}), 0);
    chk("rst_rgb", int'({red, green, blue}), 0);
    chk("rst_disp_fd", int'({disp_on, frame_done}), 0);
    chk_drop("rst_drop", 0);

    // First pixel and its latency from the second wr rising edge
    send(1'b0, 8'h2C);
    send(1'b1, 8'hF8);
    m_byte(1'b1, 8'h00);
    @(negedge clk_100);
    bus.lcd_db = 8'h00; bus.lcd_d_c = 1'b1; bus.lcd_wr = 1'b0;
    repeat (HOLD) @(negedge clk_100);
    bus.lcd_wr = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk_100);
      #1;
      if (pix_valid) lat = k;
    end
    chk("latency", lat, SYNC + 2);
    drain();
    chk_at("t1", 0, 0, 0, 0);
    if (obs_q.size() > 0) chk("t1_rgb", int'({obs_q[0].r, obs_q[0].g, obs_q[0].b}), 12'hF00);
    check_pix("t1");

    // Small window with wrap and frame_done
    send(1'b0, 8'h01);
    send4(8'h2A, 10, 11);
    send4(8'h2B, 20, 21);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 8'($urandom));
      send(1'b1, 8'($urandom));
    end
    drain();
    for (int i = 0; i < 5; i++) chk_at("t2", i, ex[i], ey[i], ef[i]);
    check_pix("t2");

    // Half pixel discarded by a command abort
    send(1'b0, 8'h01);
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAB);
    send(1'b0, 8'h2C);
    send(1'b1, 8'h07);
    send(1'b1, 8'hE0);
    drain();
    chk_at("t3", 0, 0, 0, 0);
    if (obs_q.size() > 0) chk("t3_green", int'(obs_q[0].g), 4'hF);
    chk_drop("t3_drop", 1);
    check_pix("t3");

    // Unknown command swallows data; next RAMWR starts at window start
    send(1'b0, 8'h01);
    send4(8'h2A, 7, 9);
    send(1'b0, 8'hB1);
    send(1'b1, 8'h11); send(1'b1, 8'h22); send(1'b1, 8'h33);
    send(1'b0, 8'h2C);
    send(1'b1, 8'h12); send(1'b1, 8'h34);
    drain();
    chk("t4_count", obs_q.size(), 1);
    chk_at("t4", 0, 7, 0, 0);
    check_pix("t4");

    // Clamp to WIDTH-1, then invalid window drops pixels
    send(1'b0, 8'h01);
    send4(8'h2A, 318, 400);
    send4(8'h2B, 5, 6);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 3; i++) begin send(1'b1, 8'h55); send(1'b1, 8'hAA); end
    drain();
    chk_at("t5a", 0, 318, 5, 0);
    chk_at("t5b", 1, 319, 5, 0);
    chk_at("t5c", 2, 318, 6, 0);
    check_pix("t5");
    send4(8'h2A, 50, 40);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 2; i++) begin send(1'b1, 8'hFF); send(1'b1, 8'hFF); end
    drain();
    chk("t5_invalid_count", obs_q.size(), 0);
    chk_drop("t5_drop", 2);
    check_pix("t5inv");

    // lcd_reset mid-pixel
    send(1'b0, 8'h01);
    send4(8'h2A, 10, 11);
    send(1'b0, 8'h29);
    drain();
    chk("t6_disp_on", int'(disp_on), 1);
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAB);
    @(negedge clk_100);
    bus.lcd_reset = 1'b0;
    repeat (10) @(negedge clk_100);
    bus.lcd_reset = 1'b1;
    m_reset();
    drain();
    chk("t6_disp_off", int'(disp_on), 0);
    chk_drop("t6_drop", 0);
    send(1'b1, 8'h07); send(1'b1, 8'hE0);
    send(1'b0, 8'h2C);
    send(1'b1, 8'h07); send(1'b1, 8'hE0);
    drain();
    chk("t6_count", obs_q.size(), 1);
    chk_at("t6", 0, 0, 0, 0);
    check_pix("t6");

    // Colour mapping table
    send(1'b0, 8'h01);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 7; i++) begin
      send(1'b1, tbl[i].hi);
      send(1'b1, tbl[i].lo);
      drain();
      if (obs_q.size() == i + 1) begin
        chk("tbl_rgb", int'({obs_q[i].r, obs_q[i].g, obs_q[i].b}),
            int'({tbl[i].r, tbl[i].g, tbl[i].b}));
        chk("tbl_x", int'(obs_q[i].x), i);
      end else begin
        chk("tbl_count", obs_q.size(), i + 1);
      end
    end
    check_pix("table");

    // Random byte stream against the model
    send(1'b0, 8'h01);
    for (int i = 0; i < 90; i++) begin
      int unsigned k, np;
      k = $urandom_range(0, 99);
      if (k < 14) begin
        send(1'b0, ($urandom_range(0, 1) != 0) ? 8'h2A : 8'h2B);
        np = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 4;
        for (int unsigned j = 0; j < np; j++) begin
          if (j % 2 == 0) send(1'b1, ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
          else            send(1'b1, 8'($urandom_range(0, 6)));
        end
      end else if (k < 18) send(1'b0, 8'hB1);
      else if (k < 22) send(1'b0, ($urandom_range(0, 1) != 0) ? 8'h28 : 8'h29);
      else if (k < 24) send(1'b0, 8'h01);
      else if (k < 36) send(1'b0, 8'h2C);
      else begin
        np = $urandom_range(1, 7);
        for (int unsigned j = 0; j < np; j++) send(1'b1, 8'($urandom));
      end
    end
    check_pix("random");
    chk("random_disp_on", int'(disp_on), m_disp);
    chk_drop("random_drop", m_drop);

    // Asynchronous reset with no clock edge
    send(1'b0, 8'h01);
    send(1'b0, 8'h29);
    send4(8'h2A, 5, 6);
    send(1'b0, 8'h2C);
    send(1'b1, 8'hFF); send(1'b1, 8'hFF);
    drain();
    chk("pre_reset_red_x", int'({red, pix_x}), int'({4'hF, 10'd5}));
    check_pix("pre_reset");
    @(posedge clk_100);
    #3;
    resetN = 1'b0;
    #1;
    chk("async_xy", int'({pix_x, pix_y}), 0);
    chk("async_rgb", int'({red, green, blue}), 0);
    chk("async_flags", int'({pix_valid, frame_done, disp_on}), 0);
    chk_drop("async_drop", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_bus_rx.md
Name: lcd_bus_rx

Overview:
- Receiving end of the 8-bit 8080-style LCD write bus driven by the LCD controller (lcd_db, lcd_wr, lcd_d_c, lcd_rd, lcd_reset).
- Decodes the command/parameter byte stream and reassembles RGB565 pixels from byte pairs.
- Emits each pixel with its window-tracked x/y address as 4-bit R/G/B, matching the VGA chain colour depth.
- Used as a panel model in the bench and as an on-chip loopback/scope tap for the LCD path.

Parameters:
- WIDTH, 320, panel columns; column addresses are clamped to WIDTH-1.
- HEIGHT, 240, panel rows; row addresses are clamped to HEIGHT-1.
- SYNC_STAGES, 2, flops on each bus input before edge detection. 0 means direct sampling, for a bus driven on the same clk_100.

Ports:
- clk_100  in  1  block clock.
- resetN  in  1  asynchronous, active-low reset.
- lcd_db  in  8  bus data.
- lcd_wr  in  1  write strobe; a byte is taken on the rising edge.
- lcd_d_c  in  1  0 = command byte, 1 = data/parameter byte.
- lcd_rd  in  1  read strobe; unused, must stay high.
- lcd_reset  in  1  panel reset, active low.
- pix_valid  out  1  one-cycle pulse per completed pixel.
- pix_x  out  10  column of the pixel.
- pix_y  out  10  row of the pixel.
- red  out  4  pixel colour.
- green  out  4  pixel colour.
- blue  out  4  pixel colour.
- frame_done  out  1  one-cycle pulse, coincident with pix_valid of the last pixel in the window.
- disp_on  out  1  display-on status.
- drop_cnt  out  16  dropped-pixel count; exists only when the optional feature is enabled.

Behaviour:
- Reset (resetN low, asynchronous):
  - all outputs 0;
  - window is SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1;
  - cursor is (0,0); FSM is IDLE.
- Synchronized lcd_reset low has the same effect, applied synchronously and held while low.
- Byte capture:
  - lcd_wr, lcd_d_c and lcd_db each pass through SYNC_STAGES flops.
  - A rising edge on synchronized lcd_wr latches db and d_c from the same stage.
  - With SYNC_STAGES>0, the bus must hold wr low and high for at least SYNC_STAGES+1 cycles each.
  - With SYNC_STAGES=0, single-cycle pulses are legal.
- Latency: pix_valid rises exactly SYNC_STAGES+2 cycles after the lcd_wr rising edge of the pixel's second byte.
- FSM states: IDLE, PARAM, SKIP, RAM_HI, RAM_LO.
- Any command byte, in any state, aborts the current operation, discards a half pixel, then decodes:
  - 0x01 software reset: same effect as lcd_reset; go to IDLE.
  - 0x28: disp_on<=0. 0x29: disp_on<=1. Both go to IDLE.
  - 0x2A CASET / 0x2B PASET: go to PARAM with param count 0.
    - Collect 4 bytes: start[15:8], start[7:0], end[15:8], end[7:0].
    - On the 4th byte, commit start/end truncated to 10 bits and clamped to WIDTH-1 (CASET) or HEIGHT-1 (PASET); go to IDLE.
    - A command arriving before the 4th byte leaves the window unchanged.
  - 0x2C RAMWR: cursor <= (SC,SP); go to RAM_HI.
  - Any other command: go to SKIP, where data bytes are ignored.
- Data bytes in IDLE or SKIP are ignored.
- Pixel assembly:
  - RAM_HI latches the byte as rgb[15:8] and moves to RAM_LO.
  - RAM_LO forms rgb[7:0], emits the pixel and returns to RAM_HI.
  - Colour mapping: red=rgb[15:12], green=rgb[10:7], blue=rgb[4:1].
- Cursor advance after each emitted pixel:
  - x<EC: x++.
  - x==EC and y<EP: x=SC, y++.
  - x==EC and y==EP: frame_done pulses with this pixel, cursor wraps to (SC,SP).
- Invalid window (SC>EC or SP>EP):
  - pixels are assembled but dropped (no pix_valid);
  - cursor does not move.
- pix_x, pix_y, red, green and blue hold their last values between pulses.
- lcd_rd low is ignored; no read data is returned.

Optional Feature:
- Macro: LCD_RX_DROP_CNT_EN.
- Defined:
  - drop_cnt is a 16-bit counter that saturates at 0xFFFF;
  - it increments for each pixel dropped by an invalid window, and for each half pixel discarded by a command abort;
  - it is cleared by resetN, lcd_reset and command 0x01.
- Undefined: the drop_cnt port and its logic are absent.

Test Plan:
- Default window, RAMWR, data 0xF8, 0x00 -> one pix_valid at (0,0), red=F, green=0, blue=0, exactly SYNC_STAGES+2 cycles after the 2nd wr edge.
- CASET 10..11, PASET 20..21, RAMWR, 5 pixels -> coordinates (10,20), (11,20), (10,21), (11,21) with frame_done on the 4th, then (10,20).
- RAMWR, data 0xAB, then command 0x2C, data 0x07, 0xE0 -> single pixel at (SC,SP) with green=F; drop_cnt=1 when the macro is defined.
- Command 0xB1 with 3 data bytes, then RAMWR and one pixel -> no pixel from the 0xB1 bytes; the pixel is at the window start.
- CASET 0..400 -> EC clamped to 319; CASET 50..40 then RAMWR with 2 pixels -> no pix_valid; drop_cnt=2 when the macro is defined.
- 0x29 then lcd_reset low for 10 cycles mid-pixel -> disp_on=0, window restored to default, the half pixel is lost. Separately, resetN low -> all outputs 0 with no clock edge required.
